sha256_kfetch: RTL and testbench
================================

Name: sha256_kfetch

Overview:
- Sequencer directly upstream of the round engine and the consumer of the K-constant ROM macro.
- Per block, drives ROM chip-select/address for words 0..63 and absorbs the macro's one-cycle read latency.
  - The macro captures the address on posedge and updates data on negedge; the block samples it on the next posedge.
- Delivers K[t] to the round engine over a valid/ready stream through a small skid FIFO, with t index, last flag and a done pulse.

Parameters:
- FIFO_DEPTH, 2, output skid FIFO entries (power of 2, >=2).
- NUM_WORDS, 64, words per pass (fixed by SHA-256; the address counter is 6 bits).

Ports:
- clk  input  1  system clock; also drives ROM clk0.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse; begins a 64-word pass when idle.
- abort  input  1  single-cycle pulse; cancels the pass and flushes.
- busy  output  1  high from accepted start until done or abort.
- done  output  1  one-cycle pulse when word 63 is popped.
- rom_cs  output  1  ROM cs0, combinational from state/credit.
- rom_addr  output  6  ROM addr0.
- rom_dout  input  32  ROM dout0.
- k_valid  output  1  FIFO head valid.
- k_ready  input  1  round engine accepts head.
- k_data  output  32  K word at head.
- k_idx  output  6  t of head word.
- k_last  output  1  head is word 63.

Behaviour:
- Reset (clk edge with rst_n=0), all outputs 0: busy=0, done=0, rom_cs=0, rom_addr=0, k_valid=0, k_data=0, k_idx=0, k_last=0.
  - FIFO empty, issue counter=0, in-flight flag=0, state IDLE.
  - Reset mid-pass drops everything; the stale ROM word is never written to the FIFO.
- States IDLE, FETCH, DRAIN.
  - IDLE: start -> FETCH, busy=1, issue counter=0.
  - FETCH: issue while credit is available. After word 63 is issued -> DRAIN.
  - DRAIN: no issues. When the FIFO is empty and none in flight, and the pop of word 63 occurs -> IDLE, done=1 that cycle, busy=0 next cycle.
- Issue rule: rom_cs=1 in a cycle iff state==FETCH and (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = k_valid & k_ready.
  - rom_addr = issue counter. The counter increments on each issue.
  - When rom_cs=0, rom_addr holds its last value.
- Capture: inflight is a registered copy of rom_cs. When inflight=1 at a posedge, rom_dout is written to the FIFO tail with idx = address issued the previous cycle and last = (idx==63).
- Throughput: with k_ready held high, one word per cycle sustained.
- Latency: start accepted at edge E0 -> rom_cs=1 addr 0 during cycle E0..E1 -> k_valid=1 after E2 with k_idx=0.
  - Full pass with k_ready=1: words appear after E2..E65, done after E65.
- FIFO:
  - Simultaneous push and pop on full or empty is legal and keeps the count unchanged.
  - The issue rule guarantees no overflow; overflow is impossible by construction.
  - k_data/k_idx/k_last are stable while k_valid=1 and k_ready=0.
- Event priority:
  - start while busy: ignored.
  - abort: highest priority below reset. Next cycle: FIFO empty, inflight cleared, the in-flight ROM word is discarded, state IDLE, busy=0, no done.
  - abort and start in the same cycle: abort wins; start is ignored.
- k_ready while k_valid=0 has no effect.

Optional Feature:
- Macro: SHA256_KFETCH_PERF_EN.
- When defined, adds port stall_cnt output 8.
  - Increments each cycle busy=1 and k_valid=0 and k_ready=1 (consumer starved).
  - Saturates at 255; clears on accepted start and on reset.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. ROM model loaded with the standard K table; start, k_ready=1 -> 64 words on consecutive cycles: first k_data=32'h428a2f98 idx 0 two cycles after start; idx 63 = 32'hc67178f2 with k_last=1; done one pulse; busy low next cycle.
2. k_ready toggled 1,0,0,1 repeatedly -> no loss or duplication; idx strictly 0..63; head is stable while stalled; rom_cs never asserts with credit exhausted (count+inflight<=2).
3. k_ready held 0 after start -> exactly 2 words buffered, rom_cs=0 thereafter. Releasing ready resumes with idx 0,1,2 in order.
4. Abort at idx 30 while a read is in flight -> next cycle k_valid=0, busy=0, no done. A new start restarts at idx 0 with data 32'h428a2f98.
5. rst_n=0 mid-pass for one cycle -> all outputs 0; the following start yields a correct full pass. start asserted during busy is ignored (idx sequence unbroken).
6. With SHA256_KFETCH_PERF_EN: k_ready=1 throughout -> stall_cnt=2 (the startup bubble). With the ready-toggling stimulus of scenario 2, stall_cnt stays 2 (stalls caused by the consumer are not counted).

Source files
------------

// File: rtl/sha256_kfetch.sv
// sha256_kfetch - K-constant fetch sequencer for the SHA-256 round engine.
//
// For each 64-word pass this block issues chip-select/address to the K ROM
// macro, absorbs the macro's one-cycle read latency and hands K[t] to the
// round engine over a valid/ready stream through a small skid FIFO.
// A ROM read is only issued when a FIFO slot is guaranteed for it, so the
// FIFO can never overflow.
//
// Ports:
//   clk        system clock (also clocks the ROM macro)
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse, begins a pass when idle (ignored while busy)
//   abort      one-cycle pulse, cancels the pass and flushes everything
//   busy       high from accepted start until done or abort
//   done       one-cycle pulse in the cycle word 63 is popped
//   rom_cs     ROM chip select (combinational from state and credit)
//   rom_addr   ROM address (the issue counter)
//   rom_dout   ROM read data, valid one cycle after the issue
//   k_valid    FIFO head valid
//   k_ready    round engine accepts the head
//   k_data     K word at the head
//   k_idx      round index t of the head word
//   k_last     head is word 63
//   stall_cnt  (only with SHA256_KFETCH_PERF_EN) saturating count of cycles
//              the consumer was ready while busy but nothing was valid
//
// Optional feature macro: SHA256_KFETCH_PERF_EN

module sha256_kfetch #(
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_WORDS  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        rom_cs,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic        k_valid,
    input  logic        k_ready,
    output logic [31:0] k_data,
    output logic [5:0]  k_idx,
    output logic        k_last
`ifdef SHA256_KFETCH_PERF_EN
    ,
    output logic [7:0]  stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
    } entry_t;

    state_t             state_q, state_d;
    logic [5:0]         issue_cnt_q, issue_cnt_d;
    logic               inflight_q, inflight_d;
    logic [5:0]         inflight_idx_q, inflight_idx_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];

    entry_t             head;
    logic               pop;
    logic               push;
    logic [CNT_W:0]     occupancy;

    assign head     = mem_q[rd_ptr_q];
    assign k_valid  = (count_q != '0);
    assign k_data   = head.data;
    assign k_idx    = head.idx;
    assign k_last   = head.last;
    assign pop      = k_valid & k_ready;
    assign push     = inflight_q;
    assign busy     = (state_q != S_IDLE);
    assign rom_addr = issue_cnt_q;

    // Slots already claimed after this cycle's pop: buffered words plus the
    // word still inside the ROM. Issuing only below FIFO_DEPTH means every
    // read has a slot waiting when its data lands.
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign rom_cs    = (state_q == S_FETCH) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    // Abort has priority, so the final pop during an abort is not reported.
    assign done = (state_q == S_DRAIN) && pop && head.last && !abort;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        issue_cnt_d    = issue_cnt_q;
        inflight_d     = inflight_q;
        inflight_idx_d = inflight_idx_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        mem_d          = mem_q;

        if (abort) begin
            // Flush: the word still in the ROM is dropped by clearing inflight.
            state_d    = S_IDLE;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = rom_cs;
            if (rom_cs) begin
                inflight_idx_d = issue_cnt_q;
                issue_cnt_d    = issue_cnt_q + 6'd1;
            end

            if (push) begin
                mem_d[wr_ptr_q] = '{data: rom_dout,
                                    idx:  inflight_idx_q,
                                    last: (inflight_idx_q == LAST_IDX)};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        issue_cnt_d = '0;
                    end
                end
                S_FETCH: begin
                    if (rom_cs && (issue_cnt_q == LAST_IDX)) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            issue_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            // NOTE: the FIFO storage is reset as well because the head word is
            // driven straight onto k_data/k_idx/k_last, which must read 0 after
            // reset; at this depth the cost is a handful of flops.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            issue_cnt_q    <= issue_cnt_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            mem_q          <= mem_d;
        end
    end

`ifdef SHA256_KFETCH_PERF_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            stall_cnt_d = '0;
        end else if (busy && !k_valid && k_ready && (stall_cnt_q != 8'hff)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_kfetch.sv
// tb_sha256_kfetch - self-checking bench for sha256_kfetch.
//
// A ROM macro model (address on posedge, data on negedge) holds the standard
// K table. The reference model works per word: it remembers the cycle each
// round index was issued, a word becomes visible two cycles later, and the
// number of words issued but not yet consumed may never exceed the FIFO depth.
// Inputs are driven just after posedge; outputs are sampled on negedge.

module tb_sha256_kfetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        rom_cs;
    logic [5:0]  rom_addr;
    logic [31:0] rom_dout = '0;
    logic        k_valid;
    logic        k_ready;
    logic [31:0] k_data;
    logic [5:0]  k_idx;
    logic        k_last;
`ifdef SHA256_KFETCH_PERF_EN
    logic [7:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    sha256_kfetch #(.FIFO_DEPTH(DEPTH), .NUM_WORDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .k_valid  (k_valid),
        .k_ready  (k_ready),
        .k_data   (k_data),
        .k_idx    (k_idx),
        .k_last   (k_last)
`ifdef SHA256_KFETCH_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    logic [31:0] k_rom [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ROM macro model: address captured on posedge, data updated on negedge.
    logic [5:0] rom_lat = '0;
    logic       rom_pend = 1'b0;
    always @(posedge clk) begin
        rom_pend <= rom_cs;
        if (rom_cs) rom_lat <= rom_addr;
    end
    always @(negedge clk) begin
        if (rom_pend) rom_dout <= k_rom[rom_lat];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int m_cyc = 0;
    bit m_busy = 1'b0;
    int m_issued = 0;
    int m_popped = 0;
    int m_issue_cyc [64];
    int m_stall = 0;

    // Last sampled outputs, for scenario-level checks.
    logic        s_valid, s_done, s_busy, s_cs, s_last;
    logic [31:0] s_data;
    logic [5:0]  s_idx;
    logic [7:0]  s_stall;

    task automatic model_clear();
        m_busy   = 1'b0;
        m_issued = 0;
        m_popped = 0;
    endtask

    // One clock cycle: drive inputs, sample and check on negedge, update model.
    task automatic step(input logic rdy, input logic st, input logic ab);
        bit e_valid, e_pop, e_cs, e_done, busy_pre;
        k_ready = rdy;
        start   = st;
        abort   = ab;
        @(negedge clk);
        m_cyc++;
        busy_pre = m_busy;
        e_valid = m_busy && (m_popped < m_issued) && (m_issue_cyc[m_popped] <= m_cyc - 2);
        e_pop   = e_valid && rdy;
        e_cs    = m_busy && (m_issued < 64) && ((m_issued - m_popped - int'(e_pop)) < DEPTH);
        e_done  = e_pop && (m_popped == 63) && !ab;

        s_valid = k_valid; s_done = done; s_busy = busy; s_cs = rom_cs;
        s_data  = k_data;  s_idx  = k_idx; s_last = k_last;
`ifdef SHA256_KFETCH_PERF_EN
        s_stall = stall_cnt;
        check("stall_cnt", stall_cnt, m_stall);
`else
        s_stall = '0;
`endif
        check("busy", busy, m_busy);
        check("k_valid", k_valid, e_valid);
        check("rom_cs", rom_cs, e_cs);
        check("done", done, e_done);
        if (e_cs) check("rom_addr", rom_addr, 32'(m_issued));
        if (e_valid) begin
            check("k_data", k_data, k_rom[m_popped]);
            check("k_idx", k_idx, 32'(m_popped));
            check("k_last", k_last, 32'(m_popped == 63));
        end

        if (busy_pre && !e_valid && rdy && m_stall < 255) m_stall++;
        if (ab) begin
            model_clear();
        end else begin
            if (e_cs) begin
                m_issue_cyc[m_issued] = m_cyc;
                m_issued++;
            end
            if (e_pop) m_popped++;
            if (e_done) m_busy = 1'b0;
            if (!busy_pre && st) begin
                m_busy   = 1'b1;
                m_issued = 0;
                m_popped = 0;
                m_stall  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        k_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_k_valid", k_valid, 0);
        check("rst_k_data", k_data, 0);
        check("rst_k_idx", k_idx, 0);
        check("rst_k_last", k_last, 0);
`ifdef SHA256_KFETCH_PERF_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        rst_n = 1'b1;
        model_clear();
        m_stall = 0;
    endtask

    initial begin
        int n_cs;
        int n_done;

        do_reset();

        // 1: full pass with the consumer always ready.
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check("s1_bubble_valid", s_valid, 0);
        step(1, 0, 0);
        check("s1_first_data", s_data, 32'h428a2f98);
        check("s1_first_idx", s_idx, 0);
        for (int k = 4; k <= 65; k++) step(1, 0, 0);
        step(1, 0, 0);
        check("s1_last_data", s_data, 32'hc67178f2);
        check("s1_last_flag", s_last, 1);
        check("s1_done", s_done, 1);
        step(1, 0, 0);
        check("s1_busy_after", s_busy, 0);
        check("s1_done_once", s_done, 0);
`ifdef SHA256_KFETCH_PERF_EN
        check("s1_stall", s_stall, 2);
`endif

        // 2: consumer ready pattern 1,1,0,0 from the first busy cycle.
        step(0, 1, 0);
        for (int k = 1; k <= 140; k++) step(logic'(((k - 1) % 4) < 2), 0, 0);
        check("s2_idle", s_busy, 0);
`ifdef SHA256_KFETCH_PERF_EN
        check("s2_stall", s_stall, 2);
`endif

        // 3: consumer blocked, exactly FIFO_DEPTH words get buffered.
        step(0, 1, 0);
        n_cs = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0);
            n_cs += int'(s_cs);
        end
        check("s3_buffered", n_cs, DEPTH);
        check("s3_valid", s_valid, 1);
        check("s3_no_cs", s_cs, 0);
        check("s3_head_idx", s_idx, 0);
        for (int k = 0; k < 80; k++) step(1, 0, 0);
        check("s3_idle", s_busy, 0);

        // 4: abort while word 30 is at the head and word 31 is in flight.
        step(1, 1, 0);
        for (int k = 1; k <= 32; k++) step(1, 0, 0);
        step(0, 0, 1);
        check("s4_abort_head", s_idx, 30);
        step(1, 0, 0);
        check("s4_valid_after", s_valid, 0);
        check("s4_busy_after", s_busy, 0);
        check("s4_no_done", s_done, 0);
        step(1, 1, 0);
        for (int k = 1; k <= 3; k++) step(1, 0, 0);
        check("s4_restart_data", s_data, 32'h428a2f98);
        check("s4_restart_idx", s_idx, 0);
        for (int k = 0; k < 70; k++) step(1, 0, 0);

        // 5: reset mid-pass, then a full pass with start pulses while busy.
        step(1, 1, 0);
        for (int k = 1; k <= 20; k++) step(logic'($urandom_range(0, 1)), logic'(k % 5 == 0), 0);
        do_reset();
        step(1, 1, 0);
        n_done = 0;
        for (int k = 1; k <= 67; k++) begin
            step(1, logic'((k % 7 == 0) && (k < 60)), 0);
            n_done += int'(s_done);
        end
        check("s5_one_done", n_done, 1);
        check("s5_idle", s_busy, 0);

        // Random consumer back-pressure, start spam and rare aborts.
        for (int p = 0; p < 4; p++) begin
            step(logic'($urandom_range(0, 1)), 1, 0);
            for (int k = 0; k < 250; k++) begin
                step(logic'($urandom_range(0, 3) != 0),
                     logic'($urandom_range(0, 15) == 0),
                     logic'($urandom_range(0, 299) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
